// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard and sequencing controller for the 5-stage RV32 pipeline.
//            It produces operand forwarding, stall and flush controls, and
//            sequences load-use, branch, memory-wait and post-reset flushes.
// Options  : HAZARD_PERF_EN builds the stall/flush/memory-wait counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int WIDTH             = 32,
  parameter int INIT_FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             PCSrcE,
  input  logic             MemBusyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [WIDTH-1:0] StallCnt,
  output logic [WIDTH-1:0] FlushCnt,
  output logic [WIDTH-1:0] MemWaitCnt
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] c_SRC_LOAD = 2'b01;
  localparam logic [1:0] c_FWD_RD   = 2'b00;
  localparam logic [1:0] c_FWD_W    = 2'b01;
  localparam logic [1:0] c_FWD_M    = 2'b10;

  state_t     r_state;
  logic [3:0] r_init_cnt;

  logic [4:0] r_rs1_e;
  logic [4:0] r_rs2_e;
  logic [4:0] r_rd_e;
  logic       r_reg_write_e;
  logic [1:0] r_result_src_e;
  logic [4:0] r_rd_m;
  logic       r_reg_write_m;
  logic [4:0] r_rd_w;
  logic       r_reg_write_w;

  logic w_in_init;
  logic w_lw_stall;
  logic w_mem_hold;
  logic w_branch;
  logic w_lw_take;

  assign w_lw_stall = r_reg_write_e && (r_result_src_e == c_SRC_LOAD) &&
                      (r_rd_e != 5'd0) &&
                      ((r_rd_e == Rs1D) || (r_rd_e == Rs2D));

  // Priority chain: INIT, then memory wait, then branch, then load-use.
  assign w_in_init  = (r_state == S_INIT);
  assign w_mem_hold = !w_in_init && MemBusyM;
  assign w_branch   = !w_in_init && !MemBusyM && PCSrcE;
  assign w_lw_take  = !w_in_init && !MemBusyM && !PCSrcE && w_lw_stall;

  assign StallF = w_mem_hold || w_lw_take;
  assign StallD = w_mem_hold || w_lw_take;
  assign StallE = w_mem_hold;
  assign StallM = w_mem_hold;
  assign FlushD = w_in_init || w_branch;
  assign FlushE = w_in_init || w_branch || w_lw_take;
  assign FlushW = w_mem_hold;

  always_comb begin
    ForwardAE = c_FWD_RD;
    if (r_reg_write_m && (r_rd_m != 5'd0) && (r_rd_m == r_rs1_e))
      ForwardAE = c_FWD_M;
    else if (r_reg_write_w && (r_rd_w != 5'd0) && (r_rd_w == r_rs1_e))
      ForwardAE = c_FWD_W;
  end

  always_comb begin
    ForwardBE = c_FWD_RD;
    if (r_reg_write_m && (r_rd_m != 5'd0) && (r_rd_m == r_rs2_e))
      ForwardBE = c_FWD_M;
    else if (r_reg_write_w && (r_rd_w != 5'd0) && (r_rd_w == r_rs2_e))
      ForwardBE = c_FWD_W;
  end

  // Shadow destination fields track the real pipeline registers exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rs1_e        <= 5'd0;
      r_rs2_e        <= 5'd0;
      r_rd_e         <= 5'd0;
      r_reg_write_e  <= 1'b0;
      r_result_src_e <= 2'b00;
      r_rd_m         <= 5'd0;
      r_reg_write_m  <= 1'b0;
      r_rd_w         <= 5'd0;
      r_reg_write_w  <= 1'b0;
    end else begin
      if (FlushE) begin
        r_rs1_e        <= 5'd0;
        r_rs2_e        <= 5'd0;
        r_rd_e         <= 5'd0;
        r_reg_write_e  <= 1'b0;
        r_result_src_e <= 2'b00;
      end else if (!StallE) begin
        r_rs1_e        <= Rs1D;
        r_rs2_e        <= Rs2D;
        r_rd_e         <= RdD;
        r_reg_write_e  <= RegWriteD;
        r_result_src_e <= ResultSrcD;
      end

      if (!StallM) begin
        r_rd_m        <= r_rd_e;
        r_reg_write_m <= r_reg_write_e;
      end

      if (FlushW) begin
        r_rd_w        <= 5'd0;
        r_reg_write_w <= 1'b0;
      end else begin
        r_rd_w        <= r_rd_m;
        r_reg_write_w <= r_reg_write_m;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= 4'(INIT_FLUSH_CYCLES);
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_cnt <= r_init_cnt - 4'd1;
          if (r_init_cnt <= 4'd1)
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (MemBusyM)
            r_state <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          if (!MemBusyM)
            r_state <= S_RUN;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [WIDTH-1:0] r_stall_cnt;
  logic [WIDTH-1:0] r_flush_cnt;
  logic [WIDTH-1:0] r_mem_wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
      r_mem_wait_cnt <= '0;
    end else begin
      if (w_lw_take)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_branch)
        r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_mem_hold)
        r_mem_wait_cnt <= r_mem_wait_cnt + 1'b1;
    end
  end

  assign StallCnt   = r_stall_cnt;
  assign FlushCnt   = r_flush_cnt;
  assign MemWaitCnt = r_mem_wait_cnt;
`else
  assign StallCnt   = '0;
  assign FlushCnt   = '0;
  assign MemWaitCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int WIDTH = 32;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] CTL_IDLE = 7'b0000000;
  localparam logic [6:0] CTL_INIT = 7'b0000110;
  localparam logic [6:0] CTL_BR   = 7'b0000110;
  localparam logic [6:0] CTL_LW   = 7'b1100010;
  localparam logic [6:0] CTL_MW   = 7'b1111001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic             RegWriteD;
  logic [1:0]       ResultSrcD;
  logic             PCSrcE, MemBusyM;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [WIDTH-1:0] StallCnt, FlushCnt, MemWaitCnt;

  wire [6:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  wire [3:0] fwd = {ForwardAE, ForwardBE};

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.WIDTH(WIDTH), .INIT_FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .MemWaitCnt(MemWaitCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw,
                       input logic [1:0] src);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = src;
  endtask

  task automatic drain();
    set_d(0, 0, 0, 0, 0);
    PCSrcE = 0; MemBusyM = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 0; PCSrcE = 0; MemBusyM = 0;
    set_d(0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1; #1;
    checks++; if (ctl !== CTL_INIT) begin errors++; $display("FAIL reset_c1 ctl got %b exp %b", ctl, CTL_INIT); end
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL reset_fwd fwd got %b exp 0000", fwd); end
    checks++; if ({StallCnt, FlushCnt, MemWaitCnt} !== '0) begin errors++; $display("FAIL reset_cnt got %0d %0d %0d exp 0", StallCnt, FlushCnt, MemWaitCnt); end
    tick();
    checks++; if (ctl !== CTL_INIT) begin errors++; $display("FAIL reset_c2 ctl got %b exp %b", ctl, CTL_INIT); end
    tick();
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL reset_run ctl got %b exp %b", ctl, CTL_IDLE); end
  endtask

  task automatic test_forwarding();
    // add x5 ; sub x6,x5,x5 -> M forward on both operands
    set_d(1, 2, 5, 1, 0); tick();
    set_d(5, 5, 6, 1, 0); tick();
    set_d(0, 0, 0, 0, 0); #1;
    checks++; if (fwd !== 4'b1010) begin errors++; $display("FAIL fwd_m fwd got %b exp 1010", fwd); end
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL fwd_m_ctl ctl got %b exp %b", ctl, CTL_IDLE); end
    drain();
    set_d(1, 2, 5, 1, 0); tick();
    set_d(0, 0, 0, 0, 0); tick();
    set_d(5, 5, 6, 1, 0); tick();
    set_d(0, 0, 0, 0, 0); #1;
    checks++; if (fwd !== 4'b0101) begin errors++; $display("FAIL fwd_w fwd got %b exp 0101", fwd); end
    drain();
    set_d(1, 2, 0, 1, 0); tick();
    set_d(0, 0, 6, 1, 0); tick();
    set_d(0, 0, 0, 0, 0); #1;
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL fwd_x0 fwd got %b exp 0000", fwd); end
    drain();
    set_d(1, 2, 5, 1, 0); tick();
    set_d(1, 2, 9, 1, 0); tick();
    set_d(5, 9, 6, 1, 0); tick();
    set_d(0, 0, 0, 0, 0); #1;
    checks++; if (fwd !== 4'b0110) begin errors++; $display("FAIL fwd_mix fwd got %b exp 0110", fwd); end
    drain();
    set_d(1, 2, 5, 1, 0); tick();
    set_d(3, 4, 5, 1, 0); tick();
    set_d(5, 5, 6, 1, 0); tick();
    set_d(0, 0, 0, 0, 0); #1;
    checks++; if (fwd !== 4'b1010) begin errors++; $display("FAIL fwd_prio fwd got %b exp 1010", fwd); end
    drain();
    set_d(1, 2, 5, 0, 0); tick();
    set_d(5, 5, 6, 1, 0); tick();
    set_d(0, 0, 0, 0, 0); #1;
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL fwd_nowrite fwd got %b exp 0000", fwd); end
  endtask

  task automatic test_load_use();
    drain();
    set_d(1, 0, 7, 1, 2'b01); tick();
    set_d(7, 1, 8, 1, 0); #1;
    checks++; if (ctl !== CTL_LW) begin errors++; $display("FAIL lw_stall ctl got %b exp %b", ctl, CTL_LW); end
    tick();
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL lw_release ctl got %b exp %b", ctl, CTL_IDLE); end
    tick();
    set_d(0, 0, 0, 0, 0); #1;
    checks++; if (fwd !== 4'b0100) begin errors++; $display("FAIL lw_fwd fwd got %b exp 0100", fwd); end
    checks++; if (StallCnt !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL lw_cnt StallCnt got %0d exp %0d", StallCnt, PERF ? 1 : 0); end
    drain();
    set_d(1, 0, 0, 1, 2'b01); tick();
    set_d(0, 0, 8, 1, 0); #1;
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL lw_x0 ctl got %b exp %b", ctl, CTL_IDLE); end
    drain();
    set_d(1, 0, 7, 1, 2'b01); tick();
    set_d(3, 7, 8, 1, 0); #1;
    checks++; if (ctl !== CTL_LW) begin errors++; $display("FAIL lw_rs2 ctl got %b exp %b", ctl, CTL_LW); end
    tick();
    checks++; if (StallCnt !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL lw_cnt2 StallCnt got %0d exp %0d", StallCnt, PERF ? 2 : 0); end
  endtask

  task automatic test_branch();
    drain();
    set_d(1, 2, 3, 1, 0); PCSrcE = 1; #1;
    checks++; if (ctl !== CTL_BR) begin errors++; $display("FAIL br_flush ctl got %b exp %b", ctl, CTL_BR); end
    tick();
    PCSrcE = 0; #1;
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL br_one_cycle ctl got %b exp %b", ctl, CTL_IDLE); end
    drain();
    set_d(1, 0, 7, 1, 2'b01); tick();
    set_d(7, 1, 8, 1, 0); PCSrcE = 1; #1;
    checks++; if (ctl !== CTL_BR) begin errors++; $display("FAIL br_over_lw ctl got %b exp %b", ctl, CTL_BR); end
    tick();
    PCSrcE = 0; set_d(0, 0, 0, 0, 0); #1;
    checks++; if (FlushCnt !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL br_cnt FlushCnt got %0d exp %0d", FlushCnt, PERF ? 2 : 0); end
  endtask

  task automatic test_mem_wait();
    drain();
    set_d(1, 2, 5, 1, 0); tick();
    set_d(5, 5, 6, 1, 0); tick();
    set_d(0, 0, 0, 0, 0);
    MemBusyM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== CTL_MW) begin errors++; $display("FAIL mw_ctl cycle %0d ctl got %b exp %b", i, ctl, CTL_MW); end
      checks++; if (fwd !== 4'b1010) begin errors++; $display("FAIL mw_fwd cycle %0d fwd got %b exp 1010", i, fwd); end
      tick();
    end
    MemBusyM = 0; #1;
    checks++; if (ctl !== CTL_BR) begin errors++; $display("FAIL mw_release ctl got %b exp %b", ctl, CTL_BR); end
    checks++; if (fwd !== 4'b1010) begin errors++; $display("FAIL mw_release_fwd fwd got %b exp 1010", fwd); end
    tick();
    PCSrcE = 0; #1;
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL mw_after ctl got %b exp %b", ctl, CTL_IDLE); end
    checks++; if (MemWaitCnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL mw_cnt MemWaitCnt got %0d exp %0d", MemWaitCnt, PERF ? 3 : 0); end
    checks++; if (FlushCnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL mw_flushcnt FlushCnt got %0d exp %0d", FlushCnt, PERF ? 3 : 0); end
  endtask

  task automatic test_reset_mid_wait();
    drain();
    set_d(1, 2, 5, 1, 0); tick();
    set_d(0, 0, 0, 0, 0); tick();
    MemBusyM = 1; #1;
    checks++; if (ctl !== CTL_MW) begin errors++; $display("FAIL rmw_wait ctl got %b exp %b", ctl, CTL_MW); end
    tick();
    rst_n = 0; tick();
    rst_n = 1;
    set_d(5, 5, 6, 1, 0); #1;
    checks++; if (ctl !== CTL_INIT) begin errors++; $display("FAIL rmw_init ctl got %b exp %b", ctl, CTL_INIT); end
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL rmw_init_fwd fwd got %b exp 0000", fwd); end
    checks++; if ({StallCnt, FlushCnt, MemWaitCnt} !== '0) begin errors++; $display("FAIL rmw_cnt got %0d %0d %0d exp 0", StallCnt, FlushCnt, MemWaitCnt); end
    tick();
    MemBusyM = 0; #1;
    checks++; if (ctl !== CTL_INIT) begin errors++; $display("FAIL rmw_init2 ctl got %b exp %b", ctl, CTL_INIT); end
    tick();
    checks++; if (ctl !== CTL_IDLE) begin errors++; $display("FAIL rmw_run ctl got %b exp %b", ctl, CTL_IDLE); end
    tick();
    set_d(0, 0, 0, 0, 0); #1;
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL rmw_nofwd fwd got %b exp 0000", fwd); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and pipeline-sequencing controller for the 5-stage RV32 core (F/D/E/M/W).
- Keeps a shadow copy of the E/M/W register-destination fields, which it advances in lockstep with the real pipeline registers.
- Produces the forwarding selects for the E-stage ALU operands, and the stall and flush enables for every pipeline register.
- Sequences load-use stalls, taken-branch/jump flushes, multi-cycle data-memory waits and the post-reset pipeline flush.

Parameters:
- WIDTH, 32, datapath width; used only by the optional counters.
- INIT_FLUSH_CYCLES, 2, number of cycles after reset release during which D and E are held flushed (range 1..15).

Ports:
- clk  input  1  core clock; rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- Rs1D  input  5  InstrD[19:15].
- Rs2D  input  5  InstrD[24:20].
- RdD  input  5  InstrD[11:7].
- RegWriteD  input  1  decoded register-write enable.
- ResultSrcD  input  2  decoded result select; 2'b01 = load.
- PCSrcE  input  1  branch taken or jump resolved in E.
- MemBusyM  input  1  data memory not ready; the M-stage access must be held.
- StallF  output  1  hold the PC register.
- StallD  output  1  hold the F/D register.
- StallE  output  1  hold the D/E register.
- StallM  output  1  hold the E/M register.
- FlushD  output  1  clear the F/D register.
- FlushE  output  1  clear the D/E register (bubble).
- FlushW  output  1  clear the M/W register (bubble).
- ForwardAE  output  2  ALU operand A select: 00 RD1E, 01 ResultW, 10 ALUResultM.
- ForwardBE  output  2  ALU operand B select: same encoding as ForwardAE.
- StallCnt  output  WIDTH  load-use stall cycle count (optional feature).
- FlushCnt  output  WIDTH  branch/jump flush event count (optional feature).
- MemWaitCnt  output  WIDTH  memory wait cycle count (optional feature).

Behaviour:
- Shadow state: Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, RdM, RegWriteM, RdW, RegWriteW.
  - A bubble is all fields zero.
  - E: on FlushE load a bubble; else on StallE hold; else load the D inputs.
  - M: on StallM hold; else load from E.
  - W: on FlushW load a bubble; else load from M.
- Reset (rst_n=0 at a clock edge):
  - All shadow fields cleared; FSM goes to INIT; init counter loaded with INIT_FLUSH_CYCLES.
  - Optional counters cleared.
  - Reset asserted mid-stall or mid-wait abandons that operation with no residue.
- FSM states:
  - INIT: FlushD=FlushE=1, all stalls 0. Counter decrements each cycle; at 1, go to RUN.
  - RUN: evaluate the hazards below.
  - MEM_WAIT: entered when MemBusyM=1.
    - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
    - Stays in MEM_WAIT while MemBusyM=1; returns to RUN the cycle MemBusyM=0, when hazards are re-evaluated combinationally.
- MEM_WAIT outputs are combinational on MemBusyM, so they are asserted in the same cycle MemBusyM rises.
- Load-use hazard, lwStall:
  - Condition: RegWriteE & ResultSrcE==01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
  - Response: StallF=StallD=1, FlushE=1.
  - Lasts exactly one cycle, because the bubble clears RegWriteE.
- Control hazard: PCSrcE=1 gives FlushD=FlushE=1.
- Priority, highest first: INIT, MemBusyM, PCSrcE, lwStall.
  - PCSrcE together with lwStall: flush only, no stall; the D instruction is wrong-path.
  - PCSrcE during MemBusyM: deferred. E is held, so PCSrcE is re-presented and acted on in the first cycle MemBusyM=0.
- Forwarding (combinational from shadow state, all states):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE=00.
  - M has priority over W. ForwardBE is identical, using Rs2E.
- x0: never forwarded, never causes a stall.
- Reset values of outputs (cycle after reset):
  - FlushD=FlushE=1.
  - StallF, StallD, StallE, StallM and FlushW are 0.
  - Forward selects 00; counters 0.

Optional Feature:
HAZARD_PERF_EN:
- Defined: StallCnt increments on each lwStall cycle taken in RUN. FlushCnt increments on each cycle PCSrcE is acted on. MemWaitCnt increments on each MEM_WAIT cycle. All counters wrap modulo 2^WIDTH.
- Undefined: no counter registers are built; the three ports are tied to 0.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1. Required: FlushD=FlushE=1 for exactly 2 cycles, then all stall/flush outputs 0; ForwardAE=ForwardBE=00.
- Forwarding: sequence add x5 then sub x6,x5,x5. Required: ForwardAE=ForwardBE=10 with sub in E. With one nop between them: 01. With rd=x0: 00.
- Load-use: lw x7 then add x8,x7,x1. Required: one cycle with StallF=StallD=FlushE=1, then add in E with ForwardAE=01; StallCnt=1.
- Branch flush: PCSrcE=1 for one cycle. Required: FlushD=FlushE=1 in that cycle only. With lwStall in the same cycle: StallF=StallD=0.
- Memory wait: MemBusyM=1 for 3 cycles, with PCSrcE=1 in E throughout. Required: StallF/D/E/M=1 and FlushW=1 for 3 cycles, FlushD=FlushE=0; then FlushD=FlushE=1 on the 4th cycle; MemWaitCnt=3.
- Reset mid-wait: rst_n=0 during MEM_WAIT. Required: the next cycle is INIT outputs, and shadow RegWriteM/RegWriteW=0 (no forwarding).
